bidir_io_sync: RTL and testbench

- Next-generation pin-muxed bidirectional IO block for the FPGA IO ring.
- Routes any of IOWidth internal output sources to any physical pin, with registered output enable/data and optional open-drain per source.
- Input path per pin: synchronizer, programmable glitch filter and sticky rise/fall event flags.
- Sits between the hostmot2-style function modules and the top-level inout pins.

---
 rtl/bidir_io_sync_pkg.sv | 16 +
 rtl/bidir_io_sync_in_filter.sv | 50 +++++
 rtl/bidir_io_sync.sv | 73 +++++++
 tb/tb_bidir_io_sync.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bidir_io_sync_pkg.sv
// Shared types and elaboration helpers for the pin-muxed bidirectional IO block.
package bidir_io_pkg;

  localparam int IO_WIDTH   = 36;
  localparam int PORT_NUM_W = 8;

  typedef logic [PORT_NUM_W-1:0] portsel_t;

  // Any select value >= IOWidth parks the pin; all-ones is the canonical park code.
  localparam portsel_t PORT_NONE = '1;

  function automatic bit portsel_fits(int io_width, int pn_width);
    return (pn_width >= 31) || ((1 << pn_width) >= io_width);
  endfunction

endpackage

// File: rtl/bidir_io_sync_in_filter.sv
// One pin's input path: synchronizer, programmable glitch filter, sticky edge flags.
module io_in_filter #(
  parameter int SyncStages = 2,
  parameter int FiltWidth  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pin,
  input  logic                 filt_en,
  input  logic [FiltWidth-1:0] filt_len,
  input  logic                 edge_clr,
  output logic                 read_data,
  output logic                 rise_evt,
  output logic                 fall_evt
);

  logic [SyncStages-1:0] sync_q;
  logic [FiltWidth-1:0]  cnt;
  logic                  rd_q;
  logic                  sync;

  assign sync = sync_q[SyncStages-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      cnt       <= '0;
      read_data <= 1'b0;
      rd_q      <= 1'b0;
      rise_evt  <= 1'b0;
      fall_evt  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin};
      rd_q   <= read_data;
      // >= so a shortened filt_len mid-count releases on the next differing cycle
      if (sync == read_data) begin
        cnt <= '0;
      end else if (!filt_en || cnt >= filt_len) begin
        read_data <= sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + FiltWidth'(1);
      end
      // a new edge outranks a clear landing in the same cycle
      rise_evt <= (read_data & ~rd_q) | (rise_evt & ~edge_clr);
      fall_evt <= (~read_data & rd_q) | (fall_evt & ~edge_clr);
    end
  end

endmodule

// File: rtl/bidir_io_sync.sv
// Pin-muxed bidirectional IO: registered source-to-pin drive plus per-pin filtered inputs.
module bidir_io_sync
  import bidir_io_pkg::*;
#(
  parameter int IOWidth      = 36,
  parameter int PortNumWidth = 8,
  parameter int SyncStages   = 2,
  parameter int FiltWidth    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [IOWidth-1:0][PortNumWidth-1:0]  portselnum,
  input  logic [IOWidth-1:0]                    oe,
  input  logic [IOWidth-1:0]                    od,
  input  logic [IOWidth-1:0]                    out_data,
  input  logic [IOWidth-1:0]                    filt_en,
  input  logic [FiltWidth-1:0]                  filt_len,
  input  logic [IOWidth-1:0]                    edge_clr,
  inout  wire  [IOWidth-1:0]                    ioport,
  output logic [IOWidth-1:0]                    read_data,
  output logic [IOWidth-1:0]                    rise_evt,
  output logic [IOWidth-1:0]                    fall_evt
);

  if (!portsel_fits(IOWidth, PortNumWidth)) begin : g_bad_portsel
    $error("PortNumWidth too narrow to address IOWidth sources");
  end
  if (SyncStages < 2) begin : g_bad_sync
    $error("SyncStages must be at least 2");
  end

  // Source terms zero-extended to the full select range, so out-of-range selects read as no-drive.
  localparam int SrcN = 1 << PortNumWidth;

  logic [SrcN-1:0]    src_en, src_val;
  logic [IOWidth-1:0] drv_en_d, drv_val_d, drv_en_q, drv_val_q;

  // Open-drain sense is inverted: out_data=1 pulls low, out_data=0 releases.
  assign src_en  = SrcN'(oe & (~od | out_data));
  assign src_val = SrcN'(~od & out_data);

  for (genvar i = 0; i < IOWidth; i++) begin : g_pin
    assign drv_en_d[i]  = src_en[portselnum[i]];
    assign drv_val_d[i] = src_val[portselnum[i]];
    assign ioport[i]    = drv_en_q[i] ? drv_val_q[i] : 1'bz;

    io_in_filter #(
      .SyncStages (SyncStages),
      .FiltWidth  (FiltWidth)
    ) u_in (
      .clk       (clk),
      .reset_n   (reset_n),
      .pin       (ioport[i]),
      .filt_en   (filt_en[i]),
      .filt_len  (filt_len),
      .edge_clr  (edge_clr[i]),
      .read_data (read_data[i]),
      .rise_evt  (rise_evt[i]),
      .fall_evt  (fall_evt[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drv_en_q  <= '0;
      drv_val_q <= '0;
    end else begin
      drv_en_q  <= drv_en_d;
      drv_val_q <= drv_val_d;
    end
  end

endmodule

// File: tb/tb_bidir_io_sync.sv
// Directed bench for bidir_io_sync; expectations queued by stimulus, checked by a negedge monitor.
module tb_bidir_io_sync;
  import bidir_io_pkg::*;

  localparam int IOW = 36;
  localparam int PNW = 8;
  localparam int FW  = 4;
  localparam int K_PIN = 0, K_RD = 1, K_RISE = 2, K_FALL = 3;
  localparam logic [IOW-1:0] ALL = {IOW{1'b1}};

  typedef struct {
    int             cyc;
    int             kind;
    logic [IOW-1:0] mask;
    logic [IOW-1:0] exp;
    string          name;
  } chk_t;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [IOW-1:0][PNW-1:0]  portselnum;
  logic [IOW-1:0]           oe, od, out_data, filt_en, edge_clr;
  logic [FW-1:0]            filt_len;
  wire  [IOW-1:0]           ioport;
  logic [IOW-1:0]           read_data, rise_evt, fall_evt;
  logic [IOW-1:0]           ext_en, ext_val;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  chk_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Board model: weak pull-up on every pin plus an external driver per pin.
  for (genvar i = 0; i < IOW; i++) begin : g_board
    pullup (ioport[i]);
    assign ioport[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  bidir_io_sync #(
    .IOWidth      (IOW),
    .PortNumWidth (PNW),
    .SyncStages   (2),
    .FiltWidth    (FW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .portselnum (portselnum),
    .oe         (oe),
    .od         (od),
    .out_data   (out_data),
    .filt_en    (filt_en),
    .filt_len   (filt_len),
    .edge_clr   (edge_clr),
    .ioport     (ioport),
    .read_data  (read_data),
    .rise_evt   (rise_evt),
    .fall_evt   (fall_evt)
  );

  function automatic logic [IOW-1:0] bm(int i);
    return IOW'(1) << i;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_at(int n, int kind, logic [IOW-1:0] mask, logic [IOW-1:0] exp, string name);
    chk_t c;
    c.cyc = cyc + n; c.kind = kind; c.mask = mask; c.exp = exp; c.name = name;
    sbq.push_back(c);
  endtask

  always @(negedge clk) begin
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].cyc <= cyc) begin
        logic [IOW-1:0] act;
        case (sbq[k].kind)
          K_PIN:   act = ioport;
          K_RD:    act = read_data;
          K_RISE:  act = rise_evt;
          default: act = fall_evt;
        endcase
        checks++;
        if ((act & sbq[k].mask) !== (sbq[k].exp & sbq[k].mask)) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %h want %h (mask %h)", sbq[k].name, cyc,
                   act & sbq[k].mask, sbq[k].exp & sbq[k].mask, sbq[k].mask);
        end
        sbq.delete(k);
      end
    end
  end

  initial begin
    reset_n = 1'b0; oe = ALL; od = '0; out_data = '0;
    filt_en = '0; filt_len = '0; edge_clr = '0; ext_en = '0; ext_val = '0;
    for (int i = 0; i < IOW; i++) portselnum[i] = PNW'(i);
    tick(3);

    // reset: pins released (pull-up wins over oe=1/out_data=0), state cleared
    exp_at(0, K_PIN,  ALL, ALL, "rst_hiz");
    exp_at(0, K_RD,   ALL, '0,  "rst_rd");
    exp_at(0, K_RISE, ALL, '0,  "rst_rise");
    exp_at(0, K_FALL, ALL, '0,  "rst_fall");
    out_data = 36'h5_5555_5555;
    reset_n  = 1'b1;
    exp_at(0, K_PIN, ALL, ALL,            "no_comb_path");
    exp_at(1, K_PIN, ALL, 36'h5_5555_5555, "drive");
    tick(1);

    // open drain on source 3
    od[3] = 1'b1; out_data[3] = 1'b1;
    exp_at(1, K_PIN, bm(3), '0, "od_low");
    tick(2);
    out_data[3] = 1'b0;
    exp_at(0, K_PIN, bm(3), '0,    "od_hold");
    exp_at(1, K_PIN, bm(3), bm(3), "od_release");
    exp_at(3, K_RD,  bm(3), '0,    "od_rd_lat");
    exp_at(4, K_RD,  bm(3), bm(3), "od_rd");
    tick(5);

    // fan-out of source 5 to pins 7 and 20, pin 9 parked
    portselnum[7] = 8'd5; portselnum[20] = 8'd5; portselnum[9] = PORT_NONE; out_data[5] = 1'b1;
    exp_at(1, K_PIN, bm(7) | bm(9) | bm(20), bm(7) | bm(9) | bm(20), "mux_hi");
    tick(1);
    out_data[5] = 1'b0;
    exp_at(0, K_PIN, bm(7) | bm(9) | bm(20), bm(7) | bm(9) | bm(20), "mux_lat");
    exp_at(1, K_PIN, bm(7) | bm(9) | bm(20), bm(9),                  "mux_lo");
    tick(2);

    // hand pin 2 to the external driver, settle, clear flags
    portselnum[2] = PORT_NONE; ext_en[2] = 1'b1; ext_val[2] = 1'b0;
    tick(8);
    edge_clr = ALL;
    tick(1);
    edge_clr = '0; filt_en[2] = 1'b1; filt_len = 4'd3;
    exp_at(0, K_RD,   bm(2), '0, "ext_low");
    exp_at(0, K_RISE, bm(2), '0, "clr_rise");
    exp_at(0, K_FALL, bm(2), '0, "clr_fall");

    // 3-cycle pulse is filtered out
    ext_val[2] = 1'b1;
    for (int k = 1; k <= 8; k++) exp_at(k, K_RD, bm(2), '0, "short_pulse_rd");
    exp_at(8, K_RISE, bm(2), '0, "short_pulse_evt");
    tick(3);
    ext_val[2] = 1'b0;
    tick(7);

    // 4-cycle pulse passes; clear collides with rise set, then clears next cycle
    ext_val[2] = 1'b1;
    exp_at(5,  K_RD,   bm(2), '0,    "long_pre");
    exp_at(6,  K_RD,   bm(2), bm(2), "long_rd");
    exp_at(6,  K_RISE, bm(2), '0,    "rise_lat");
    exp_at(7,  K_RISE, bm(2), bm(2), "clr_collide");
    exp_at(8,  K_RISE, bm(2), '0,    "clr_next");
    exp_at(9,  K_RD,   bm(2), bm(2), "long_hold");
    exp_at(10, K_RD,   bm(2), '0,    "long_fall");
    exp_at(10, K_FALL, bm(2), '0,    "fall_lat");
    exp_at(11, K_FALL, bm(2), bm(2), "fall_evt");
    exp_at(14, K_FALL, bm(2), bm(2), "fall_sticky");
    tick(4);
    ext_val[2] = 1'b0;
    tick(2);
    edge_clr[2] = 1'b1;
    tick(2);
    edge_clr[2] = 1'b0;
    tick(8);

    // shorten filt_len from 7 to 2 while cnt=5
    filt_len = 4'd7; ext_val[2] = 1'b1;
    exp_at(7, K_RD, bm(2), '0,    "reconf_pre");
    exp_at(8, K_RD, bm(2), bm(2), "reconf_now");
    tick(7);
    filt_len = 4'd2;
    tick(3);

    // reset mid-count
    filt_len = 4'd7; ext_val[2] = 1'b0;
    tick(5);
    reset_n = 1'b0;
    exp_at(0, K_RD,   ALL,     '0,  "rst_mid_rd");
    exp_at(0, K_RISE, ALL,     '0,  "rst_mid_rise");
    exp_at(0, K_FALL, ALL,     '0,  "rst_mid_fall");
    exp_at(0, K_PIN,  ~bm(2),  ALL, "rst_mid_hiz");
    tick(2);

    // counter restarts from 0 after reset
    filt_len = 4'd3; ext_val[2] = 1'b1; reset_n = 1'b1;
    exp_at(5, K_RD, bm(2), '0,    "post_rst_cnt");
    exp_at(6, K_RD, bm(2), bm(2), "post_rst_rd");
    tick(10);

    if (sbq.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
      errors += sbq.size();
      checks += sbq.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
